// File: rtl/fir_filter_if.sv
// Streaming interface for fir_filter: one sample-in channel, one result-out channel.
interface fir_filter_if;
  logic               s_axis_data_tvalid;
  logic signed [15:0] s_axis_data_tdata;
  logic               s_axis_data_tready;
  logic               m_axis_data_tvalid;
  logic signed [31:0] m_axis_data_tdata;

  // Filter side: consumes input samples, produces results
  modport slave (
    input  s_axis_data_tvalid,
    input  s_axis_data_tdata,
    output s_axis_data_tready,
    output m_axis_data_tvalid,
    output m_axis_data_tdata
  );

  // Source/sink side: drives samples, observes results
  modport master (
    output s_axis_data_tvalid,
    output s_axis_data_tdata,
    input  s_axis_data_tready,
    input  m_axis_data_tvalid,
    input  m_axis_data_tdata
  );
endinterface

// File: rtl/fir_filter.sv
// Direct-form FIR filter with a three-register pipeline:
// delay line -> registered products -> saturated sum. Output follows accept by two edges.
module fir_filter #(
  parameter int                      NUM_TAPS    = 8,
  parameter logic [NUM_TAPS*16-1:0]  COEF        = {NUM_TAPS{16'sd4096}},
  parameter int                      FILTER_TYPE = 0
) (
  input logic         aclk,
  input logic         aresetn,
  fir_filter_if.slave axis
);

  // Accumulator wide enough that the sum of all products can never wrap
  localparam int AccW = 32 + $clog2(NUM_TAPS);
  localparam logic signed [AccW-1:0] SatMax = {{(AccW - 31){1'b0}}, {31{1'b1}}};
  localparam logic signed [AccW-1:0] SatMin = {{(AccW - 31){1'b1}}, {31{1'b0}}};

  if (NUM_TAPS < 2 || NUM_TAPS > 64 || FILTER_TYPE < 0 || FILTER_TYPE > 2) begin : g_param_check
    $error("fir_filter: NUM_TAPS must be 2..64 and FILTER_TYPE 0..2");
  end

  logic signed [15:0]     taps_q [NUM_TAPS];
  logic signed [31:0]     prod_q [NUM_TAPS];
  logic                   tap_vld_q;
  logic                   prod_vld_q;
  logic                   out_vld_q;
  logic signed [31:0]     out_q;
  logic signed [AccW-1:0] acc;
  logic signed [31:0]     acc_sat;
  logic                   accept;

  function automatic logic signed [15:0] coef_at(input int k);
    return COEF[k*16 +: 16];
  endfunction

  // aresetn is active-high here; ready is withheld only while it is asserted
  assign axis.s_axis_data_tready = ~aresetn;
  assign accept                  = axis.s_axis_data_tvalid & axis.s_axis_data_tready;

  // Delay line: shifts only on an accepted sample, so gaps never insert zeros
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int k = 0; k < NUM_TAPS; k++) taps_q[k] <= '0;
      tap_vld_q <= 1'b0;
    end else begin
      tap_vld_q <= accept;
      if (accept) begin
        taps_q[0] <= axis.s_axis_data_tdata;
        for (int k = 1; k < NUM_TAPS; k++) taps_q[k] <= taps_q[k-1];
      end
    end
  end

  // Product stage: one signed 16x16 multiply per tap
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_vld_q <= tap_vld_q;
      for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= 32'(taps_q[k]) * 32'(coef_at(k));
    end
  end

  // Full-precision sum of products, clamped to the 32-bit signed range
  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) acc = acc + AccW'(prod_q[k]);
    if (acc > SatMax) begin
      acc_sat = 32'sh7fff_ffff;
    end else if (acc < SatMin) begin
      acc_sat = 32'sh8000_0000;
    end else begin
      acc_sat = acc[31:0];
    end
  end

  // Output register: data holds between valid pulses
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      out_vld_q <= prod_vld_q;
      if (prod_vld_q) out_q <= acc_sat;
    end
  end

  assign axis.m_axis_data_tvalid = out_vld_q;
  assign axis.m_axis_data_tdata  = out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Bench for fir_filter: three instances (default lowpass, saturating, highpass) share one
// input stream; each result is checked against a convolution model with cycle-exact timing.
module tb_fir_filter;

  localparam int NTaps = 8;
  localparam logic [127:0] SatCoef = {8{16'h8000}};
  localparam logic [127:0] HpCoef  = {-16'sd500, 16'sd2000, -16'sd5000, 16'sd12000,
                                      16'sd16000, -16'sd7000, 16'sd3000, -16'sd1000};

  typedef struct {
    longint val;
    int     stamp;
  } exp_t;

  logic               aclk = 1'b0;
  logic               aresetn = 1'b1;
  logic               tvalid = 1'b0;
  logic signed [15:0] tdata = '0;
  int                 cyc = 0;
  bit                 mon_en = 1'b0;
  int                 vectors = 0;
  int                 miscompares = 0;

  int     coef [3][NTaps];
  int     hist [$];
  exp_t   expq [3][$];

  fir_filter_if if_lp ();
  fir_filter_if if_sat ();
  fir_filter_if if_hp ();

  assign if_lp.s_axis_data_tvalid  = tvalid;
  assign if_lp.s_axis_data_tdata   = tdata;
  assign if_sat.s_axis_data_tvalid = tvalid;
  assign if_sat.s_axis_data_tdata  = tdata;
  assign if_hp.s_axis_data_tvalid  = tvalid;
  assign if_hp.s_axis_data_tdata   = tdata;

  fir_filter dut_lp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axis    (if_lp)
  );

  fir_filter #(.NUM_TAPS(NTaps), .COEF(SatCoef), .FILTER_TYPE(0)) dut_sat (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axis    (if_sat)
  );

  fir_filter #(.NUM_TAPS(NTaps), .COEF(HpCoef), .FILTER_TYPE(2)) dut_hp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .axis    (if_hp)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // y[n] = sum c[k]*x[n-k], missing history counts as zero, clamped to 32 bits
  function automatic longint model_y(input int d);
    longint acc = 0;
    for (int k = 0; k < NTaps; k++) begin
      if (k < hist.size()) acc += longint'(coef[d][k]) * longint'(hist[k]);
    end
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    if (acc < -64'sd2147483648) acc = -64'sd2147483648;
    return acc;
  endfunction

  task automatic send(input int x);
    exp_t e;
    tvalid = 1'b1;
    tdata  = 16'(x);
    #1;
    chk("tready_on_send", if_lp.s_axis_data_tready, 1);
    @(posedge aclk);
    #1;
    tvalid = 1'b0;
    hist.push_front(x);
    if (hist.size() > NTaps) void'(hist.pop_back());
    for (int d = 0; d < 3; d++) begin
      e.val   = model_y(d);
      e.stamp = cyc;
      expq[d].push_back(e);
    end
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset(input int n);
    aresetn = 1'b1;
    tvalid  = 1'b0;
    @(posedge aclk);
    #1;
    hist.delete();
    for (int d = 0; d < 3; d++) expq[d].delete();
    mon_en = 1'b1;
    chk("rst_tready_lp", if_lp.s_axis_data_tready, 0);
    chk("rst_tvalid_lp", if_lp.m_axis_data_tvalid, 0);
    chk("rst_tdata_lp", if_lp.m_axis_data_tdata, 0);
    chk("rst_tdata_sat", if_sat.m_axis_data_tdata, 0);
    chk("rst_tdata_hp", if_hp.m_axis_data_tdata, 0);
    repeat (n - 1) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("tready_after_rst", if_lp.s_axis_data_tready, 1);
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 20; i++) begin
      left = expq[0].size() + expq[1].size() + expq[2].size();
      if (left == 0) break;
      @(posedge aclk);
    end
    #1;
    left = expq[0].size() + expq[1].size() + expq[2].size();
    chk("drain_outstanding", left, 0);
    idle(3);
  endtask

  task automatic mon(input int d, input logic v, input logic signed [31:0] data);
    logic ev;
    exp_t e;
    ev = (expq[d].size() > 0) && (expq[d][0].stamp + 2 == cyc);
    chk($sformatf("tvalid[%0d]@%0d", d, cyc), v, ev);
    if (ev) begin
      e = expq[d].pop_front();
      chk($sformatf("tdata[%0d]@%0d", d, cyc), data, e.val);
    end
  endtask

  always @(negedge aclk) begin
    if (mon_en) begin
      mon(0, if_lp.m_axis_data_tvalid, if_lp.m_axis_data_tdata);
      mon(1, if_sat.m_axis_data_tvalid, if_sat.m_axis_data_tdata);
      mon(2, if_hp.m_axis_data_tvalid, if_hp.m_axis_data_tdata);
    end
  end

  initial begin
    int hp_c [NTaps] = '{-1000, 3000, -7000, 16000, 12000, -5000, 2000, -500};
    for (int k = 0; k < NTaps; k++) begin
      coef[0][k] = 4096;
      coef[1][k] = -32768;
      coef[2][k] = hp_c[k];
    end

    // Power-on reset
    do_reset(3);

    // Impulse, back-to-back
    send(1);
    for (int i = 0; i < 9; i++) send(0);
    drain();

    // Step of 1000 over 16 samples
    for (int i = 0; i < 16; i++) send(1000);
    drain();

    // Gapped impulse
    do_reset(2);
    send(1);
    for (int i = 0; i < 9; i++) begin
      idle($urandom_range(1, 4));
      send(0);
    end
    drain();

    // Saturation: full-scale negative inputs and coefficients
    do_reset(2);
    for (int i = 0; i < 8; i++) send(-32768);
    drain();

    // Reset mid-stream discards in-flight samples
    do_reset(2);
    for (int i = 0; i < 5; i++) send(1000);
    do_reset(10);
    send(1);
    for (int i = 0; i < 9; i++) send(0);
    drain();

    // Signed alternating full-scale, then random samples with random gaps
    for (int i = 0; i < 1000; i++) send((i % 2 == 0) ? 32767 : -32768);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send(int'($signed(16'($urandom))));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fir_filter.md
FIR_FILTER -- requirements
Module: fir_filter

Interface
REQ-001 SHALL have parameter NUM_TAPS, default 8, meaning the number of filter taps (range 2..64).
REQ-002 SHALL have parameter COEF, default NUM_TAPS copies of 16'sd4096, meaning a flat vector of NUM_TAPS signed 16-bit coefficients with c[0] in bits [15:0].
REQ-003 SHALL have parameter FILTER_TYPE, default 0, meaning an informational tag only (0 lowpass, 1 bandpass, 2 highpass); function is set by COEF alone.
REQ-004 SHALL have port aclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port aresetn, input, 1 bit: the reset, which is synchronous and active-high (asserted = 1) despite the suffix.
REQ-006 SHALL have port s_axis_data_tvalid, input, 1 bit: the input sample is valid.
REQ-007 SHALL have port s_axis_data_tdata, input, 16 bits: the signed two's-complement input sample x[n].
REQ-008 SHALL have port s_axis_data_tready, output, 1 bit: the block accepts a sample.
REQ-009 SHALL have port m_axis_data_tvalid, output, 1 bit: the output sample is valid for one cycle.
REQ-010 SHALL have port m_axis_data_tdata, output, 32 bits: the signed output sample y[n].

Function
REQ-011 SHALL accept a sample on a rising edge where s_axis_data_tvalid=1 and s_axis_data_tready=1.
REQ-012 SHALL drive s_axis_data_tready=1 on every cycle except while aresetn=1, when it is 0; the block applies no backpressure.
REQ-013 SHALL hold a NUM_TAPS-deep delay line; on each accepted sample x[n] enters tap 0 and each tap shifts by one.
REQ-014 SHALL leave the delay line unchanged on cycles with no accepted sample; input gaps do not insert zeros.
REQ-015 SHALL compute y[n] = sum over k=0..NUM_TAPS-1 of c[k]*x[n-k], using signed 16x16 to 32-bit products and a full-precision accumulator of 32+ceil(log2(NUM_TAPS)) bits.
REQ-016 SHALL saturate the accumulator to the 32-bit range: values above 2^31-1 give 2^31-1, and values below -2^31 give -2^31; there is no rounding or shift.
REQ-017 SHALL have fixed latency: for a sample accepted at edge k, m_axis_data_tvalid=1 with m_axis_data_tdata=y[n] during the cycle after edge k+2, for exactly one cycle.
REQ-018 SHALL produce exactly one output per accepted input, in order; back-to-back inputs give back-to-back outputs.
REQ-019 SHALL register m_axis_data_tdata and hold it between valid pulses; its value is don't-care while m_axis_data_tvalid=0.
REQ-020 SHALL have no output tready; the downstream consumer always accepts.

Reset
REQ-021 SHALL, on a rising edge with aresetn=1, clear all delay-line taps and pipeline registers to 0 and drive m_axis_data_tvalid=0, m_axis_data_tdata=0 and s_axis_data_tready=0.
REQ-022 SHALL discard samples in flight when reset is asserted mid-stream, with no output for them after reset.
REQ-023 SHALL, after reset deasserts, compute the first output using zeros for the earlier taps (x[n-k]=0 for k>n).

Verification
REQ-024 Impulse (default COEF): drive 16'sd1 then 9 zeros back-to-back -> 10 outputs, the first 8 equal to 4096 and the last 2 equal to 0, first valid 2 cycles after the first accept.
REQ-025 Step: drive 16 samples of 1000 -> outputs 4096000, 8192000, ... rising to 32768000 and holding at 32768000 from the 8th output on.
REQ-026 Gapped input: same impulse with 1-4 idle cycles between samples -> identical output values, each output 2 cycles after its input.
REQ-027 Saturation: all COEF=-32768, drive -32768 for 8 samples -> 8th output 2147483647 (saturated, not wrapped).
REQ-028 Reset mid-stream: drive 5 samples of 1000, assert aresetn=1 for 10 cycles, then drive an impulse of 1 -> no stale output, and outputs 4096 x8.
REQ-029 Signed mix: drive alternating +32767/-32768 with a highpass COEF set -> matches a bit-exact software model over 1000 samples.
